// File: rtl/burst_mem_pkg.sv
// Shared constants and state encoding for the burst memory responder.
package burst_mem_pkg;

  localparam int BEAT_W      = 64;
  localparam int BEATS       = 4;
  localparam int LINE_W      = BEAT_W * BEATS;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } burst_mem_state_e;

  // Line-buffer slice for a given beat.
  function automatic logic [BEAT_W-1:0] beat_of(input logic [LINE_W-1:0] line,
                                                input logic [1:0] beat);
    return line[int'(beat)*BEAT_W +: BEAT_W];
  endfunction

endpackage

// File: rtl/burst_mem_array.sv
// Whole-line storage: one asynchronous 256-bit read port, one synchronous write port.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [LINE_W-1:0] wr_line_i
);

  logic [LINE_W-1:0] mem_q [DEPTH_LINES];

  // Contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_idx_i] <= wr_line_i;
  end

  assign rd_line_o = mem_q[rd_idx_i];

endmodule

// File: rtl/burst_mem_responder.sv
// Line-granular memory responder for the 4-beat, 64-bit burst interface.
// Optional protocol checker: define BURST_MEM_PROTOCOL_CHECK_EN to build err_o logic.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [31:0]       address_i,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic              resp_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  burst_mem_state_e  state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        beat_q;
  logic [1:0]        beat_nxt;
  logic              is_wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] buf_q;
  logic              resp_q;
  logic [BEAT_W-1:0] burst_q;

  logic              req;
  logic [IDX_W-1:0]  acc_idx;
  logic [LINE_W-1:0] rd_line;
  logic              we;
  logic [LINE_W-1:0] wr_line_d;

  assign req      = read_i | write_i;
  assign acc_idx  = address_i[OFFSET_BITS +: IDX_W];
  assign beat_nxt = beat_q + 2'd1;

  // Commit on the beat-3 edge, folding in the beat arriving this cycle.
  assign we        = (state_q == S_BURST) && is_wr_q && (beat_q == 2'd3);
  assign wr_line_d = {burst_i, buf_q[LINE_W-BEAT_W-1:0]};

  burst_mem_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk       (clk),
    .rd_idx_i  (acc_idx),
    .rd_line_o (rd_line),
    .we_i      (we),
    .wr_idx_i  (idx_q),
    .wr_line_i (wr_line_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      is_wr_q <= 1'b0;
      idx_q   <= '0;
      buf_q   <= '0;
      resp_q  <= 1'b0;
      burst_q <= '0;
    end else begin
      resp_q  <= 1'b0;
      burst_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            idx_q   <= acc_idx;
            is_wr_q <= write_i;
            beat_q  <= '0;
            if (!write_i) buf_q <= rd_line;
            if (LATENCY == 0) begin
              state_q <= S_BURST;
              resp_q  <= 1'b1;
              // Buffer is loading on this same edge, so source beat 0 directly.
              burst_q <= write_i ? '0 : beat_of(rd_line, 2'd0);
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_W'(LATENCY);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_BURST;
            cnt_q   <= '0;
            resp_q  <= 1'b1;
            burst_q <= is_wr_q ? '0 : beat_of(buf_q, 2'd0);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_BURST: begin
          if (is_wr_q) buf_q[int'(beat_q)*BEAT_W +: BEAT_W] <= burst_i;
          if (beat_q == 2'd3) begin
            state_q <= S_DONE;
            beat_q  <= '0;
          end else begin
            beat_q  <= beat_nxt;
            resp_q  <= 1'b1;
            burst_q <= is_wr_q ? '0 : beat_of(buf_q, beat_nxt);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign resp_o  = resp_q;
  assign burst_o = burst_q;

`ifdef BURST_MEM_PROTOCOL_CHECK_EN
  logic [31:0] addr_q;
  logic        err_q;
  logic        busy;

  assign busy = (state_q == S_WAIT) || (state_q == S_BURST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && req) addr_q <= address_i;
      if (read_i && write_i) err_q <= 1'b1;
      if (busy && (!req || address_i != addr_q)) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Offset and out-of-range line bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{address_i[31:OFFSET_BITS+IDX_W], address_i[OFFSET_BITS-1:0]};

endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench: dut index 0 runs LATENCY=4, index 1 runs LATENCY=0.
module tb_burst_mem_responder;

  localparam int DEPTH = 256;

  logic        clk;
  logic        reset_n;
  logic        req_rd  [2];
  logic        req_wr  [2];
  logic [31:0] addr    [2];
  logic [63:0] bin     [2];
  logic [63:0] bout    [2];
  logic        resp    [2];
  logic        err     [2];

  logic [255:0] model [2][DEPTH];
  logic [63:0]  exp_q [$];
  logic         exp_err [2];
  int           n_cmp;
  int           n_err;

  burst_mem_responder #(.DEPTH_LINES(DEPTH), .LATENCY(4)) dut (
    .clk(clk), .reset_n(reset_n), .read_i(req_rd[0]), .write_i(req_wr[0]),
    .address_i(addr[0]), .burst_i(bin[0]), .burst_o(bout[0]),
    .resp_o(resp[0]), .err_o(err[0])
  );

  burst_mem_responder #(.DEPTH_LINES(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .read_i(req_rd[1]), .write_i(req_wr[1]),
    .address_i(addr[1]), .burst_i(bin[1]), .burst_o(bout[1]),
    .resp_o(resp[1]), .err_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] LINE_A = {64'h4444444444444444, 64'h3333333333333333,
                                     64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] LINE_B = {64'hDDDD0003CAFE0003, 64'hDDDD0002CAFE0002,
                                     64'hDDDD0001CAFE0001, 64'hDDDD0000CAFE0000};
  localparam logic [255:0] LINE_C = {64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0,
                                     64'h0123456789ABCDEF, 64'hFEDCBA9876543210};

`ifdef BURST_MEM_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // One full transaction from acceptance through DONE; glitch>0 changes address in that cycle.
  task automatic run_txn(input int d, input bit wr, input logic [31:0] a,
                         input logic [255:0] line, input int glitch, input string nm);
    int lat, k, idx;
    bit want;
    logic [63:0] e;
    lat = (d == 0) ? 4 : 0;
    idx = int'((a >> 5) % DEPTH);
    if (!wr) for (int i = 0; i < 4; i++) exp_q.push_back(model[d][idx][i*64 +: 64]);
    @(posedge clk); #1;
    req_rd[d] = !wr; req_wr[d] = wr; addr[d] = a;
    k = 0;
    for (int c = 1; c <= 5 + lat; c++) begin
      @(posedge clk); #1;
      if (c == glitch) addr[d] = a ^ 32'h20;
      if (c == 5 + lat) begin req_rd[d] = 1'b0; req_wr[d] = 1'b0; end
      if (wr && resp[d] === 1'b1 && k < 4) bin[d] = line[k*64 +: 64];
      @(negedge clk);
      want = (c >= 1 + lat) && (c <= 4 + lat);
      n_cmp++;
      if (resp[d] !== want) begin
        n_err++;
        $display("FAIL %s resp cycle %0d: got %b want %b", nm, c, resp[d], want);
      end
      if (resp[d] === 1'b1) begin
        if (!wr) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s extra beat cycle %0d: got %h want none", nm, c, bout[d]);
          end else begin
            e = exp_q.pop_front();
            if (bout[d] !== e) begin
              n_err++;
              $display("FAIL %s beat %0d: got %h want %h", nm, k, bout[d], e);
            end
          end
        end
        k++;
      end else begin
        n_cmp++;
        if (bout[d] !== 64'h0) begin
          n_err++;
          $display("FAIL %s burst_o idle cycle %0d: got %h want 0", nm, c, bout[d]);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s missing beats: got %0d left want 0", nm, exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (err[d] !== exp_err[d]) begin
      n_err++;
      $display("FAIL %s err_o: got %b want %b", nm, err[d], exp_err[d]);
    end
    if (wr) model[d][idx] = line;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_rd[d] = 1'b0; req_wr[d] = 1'b0; addr[d] = '0; bin[d] = '0; exp_err[d] = 1'b0;
    end
    #3 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp += 3;
      if (resp[d] !== 1'b0) begin n_err++; $display("FAIL reset resp[%0d]: got %b want 0", d, resp[d]); end
      if (bout[d] !== 64'h0) begin n_err++; $display("FAIL reset burst_o[%0d]: got %h want 0", d, bout[d]); end
      if (err[d] !== 1'b0) begin n_err++; $display("FAIL reset err[%0d]: got %b want 0", d, err[d]); end
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    run_txn(0, 1'b1, 32'h0000_0040, LINE_A, 0, "wr40");
    run_txn(0, 1'b0, 32'h0000_0040, '0, 0, "rd40");
  endtask

  task automatic test_wrap();
    run_txn(0, 1'b0, 32'h0000_2040, '0, 0, "rdwrap2040");
    run_txn(0, 1'b1, 32'hFFFF_E06B, LINE_C, 0, "wrwrapE06B");
    run_txn(0, 1'b0, 32'h0000_0060, '0, 0, "rd60");
  endtask

  task automatic test_latency0();
    run_txn(1, 1'b1, 32'h0000_0100, LINE_B, 0, "l0wr100");
    run_txn(1, 1'b0, 32'h0000_0100, '0, 0, "l0rd100");
    run_txn(1, 1'b0, 32'h0000_0100, '0, 0, "l0rd100b");
  endtask

  // read_i held through DONE: second transaction only after IDLE.
  task automatic test_back_to_back();
    int lat;
    bit want;
    logic [63:0] e;
    lat = 4;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) exp_q.push_back(model[0][2][i*64 +: 64]);
    @(posedge clk); #1;
    req_rd[0] = 1'b1; addr[0] = 32'h0000_0040;
    for (int c = 1; c <= 11 + 2*lat; c++) begin
      @(posedge clk); #1;
      if (c == 11 + 2*lat) req_rd[0] = 1'b0;
      @(negedge clk);
      want = (c >= 1 + lat && c <= 4 + lat) || (c >= 7 + 2*lat && c <= 10 + 2*lat);
      n_cmp++;
      if (resp[0] !== want) begin
        n_err++;
        $display("FAIL b2b resp cycle %0d: got %b want %b", c, resp[0], want);
      end
      if (resp[0] === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bout[0] !== e) begin
          n_err++;
          $display("FAIL b2b beat cycle %0d: got %h want %h", c, bout[0], e);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b missing beats: got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    lat = 4;
    run_txn(0, 1'b1, 32'h0000_0080, LINE_B, 0, "wr80old");
    @(posedge clk); #1;
    req_wr[0] = 1'b1; addr[0] = 32'h0000_0080;
    for (int c = 1; c <= 3 + lat; c++) begin
      @(posedge clk); #1;
      if (resp[0] === 1'b1) bin[0] = ~LINE_B[63:0] ^ 64'(c);
    end
    n_cmp++;
    if (resp[0] !== 1'b1) begin
      n_err++;
      $display("FAIL abort resp at beat2: got %b want 1", resp[0]);
    end
    reset_n = 1'b0; req_wr[0] = 1'b0;
    #1;
    n_cmp += 2;
    if (resp[0] !== 1'b0) begin n_err++; $display("FAIL abort resp drop: got %b want 0", resp[0]); end
    if (bout[0] !== 64'h0) begin n_err++; $display("FAIL abort burst_o: got %h want 0", bout[0]); end
    @(negedge clk);
    reset_n = 1'b1;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    run_txn(0, 1'b0, 32'h0000_0080, '0, 0, "rd80after");
  endtask

  task automatic test_protocol();
    exp_err[0] = CHK;
    run_txn(0, 1'b0, 32'h0000_0040, '0, 2, "glitchwait");
    run_txn(0, 1'b0, 32'h0000_0080, '0, 0, "errsticky");
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    exp_err[0] = 1'b0;
    n_cmp++;
    if (err[0] !== 1'b0) begin n_err++; $display("FAIL err clear by reset: got %b want 0", err[0]); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_write_read();
    test_wrap();
    test_latency0();
    test_back_to_back();
    test_reset_abort();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
